blob_raster: RTL

Parametrised, pixel-serial successor to the soft-body frame builder. Renders N fixed-point particles as discs into a DIM×DIM LED bitmap, paced by an internal frame timer. Evaluates one pixel per cycle against all particles in parallel instead of replicating one radius comparator per pixel per particle. Adds snapshot-consistent frames, an optional trail mode and an overrun flag. Sits between the particle array and the LED matrix driver.

---
 rtl/blob_raster_pkg.sv | 22 ++
 rtl/blob_raster_if.sv | 28 ++
 rtl/blob_raster_disc_hit.sv | 36 +++
 rtl/blob_raster.sv | 134 +++++++++++++
 4 files changed

// File: rtl/blob_raster_pkg.sv
// Shared types and constants for the blob rasteriser.
// Latency: none (declarations only).
// Backpressure: not applicable.
package blob_raster_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Width of one particle coordinate and of the on-chip pixel coordinates.
    localparam int COORD_W = 16;

    // Two squared coordinates summed need one extra bit over a single square.
    function automatic int sq_width(input int w);
        return 2 * w + 1;
    endfunction

    localparam int SQ_W = sq_width(COORD_W);

endpackage

// File: rtl/blob_raster_if.sv
// Particle-in / bitmap-out bundle between particle array, rasteriser and LED driver.
// Latency: none (wires only).
// Backpressure: none; the bitmap is level-held and frame_done is a pulse.
interface blob_raster_if
    import blob_raster_pkg::*;
#(
    parameter int N   = 4,
    parameter int DIM = 16
);
    logic [N*COORD_W-1:0] pos_x;
    logic [N*COORD_W-1:0] pos_y;
    logic                 trail_mode;
    logic                 freeze;
    logic [DIM*DIM-1:0]   matrix;
    logic                 frame_done;
    logic                 busy;
    logic                 overrun;

    modport master (
        output pos_x, pos_y, trail_mode, freeze,
        input  matrix, frame_done, busy, overrun
    );

    modport slave (
        input  pos_x, pos_y, trail_mode, freeze,
        output matrix, frame_done, busy, overrun
    );
endinterface

// File: rtl/blob_raster_disc_hit.sv
// Decides whether one pixel lies inside one particle's disc.
// Latency: combinational.
// Backpressure: none.
module disc_hit
    import blob_raster_pkg::*;
#(
    parameter int FRAC_BITS = 4,
    parameter int RADIUS_SQ = 2
) (
    input  logic signed [COORD_W-1:0] px,
    input  logic signed [COORD_W-1:0] py,
    input  logic signed [COORD_W-1:0] pos_x,
    input  logic signed [COORD_W-1:0] pos_y,
    output logic                      hit
);
    logic signed [COORD_W-1:0]   cx;
    logic signed [COORD_W-1:0]   cy;
    logic signed [COORD_W-1:0]   dx;
    logic signed [COORD_W-1:0]   dy;
    logic signed [2*COORD_W-1:0] sq_x;
    logic signed [2*COORD_W-1:0] sq_y;
    logic        [SQ_W-1:0]      dist_sq;

    // Arithmetic shift keeps negative positions rounding towards -inf.
    assign cx = pos_x >>> FRAC_BITS;
    assign cy = pos_y >>> FRAC_BITS;

    // Differences wrap at 16 bits; far-off particles simply never hit.
    assign dx = px - cx;
    assign dy = py - cy;

    assign sq_x    = dx * dx;
    assign sq_y    = dy * dy;
    assign dist_sq = {1'b0, sq_x} + {1'b0, sq_y};
    assign hit     = (dist_sq <= SQ_W'(RADIUS_SQ));
endmodule

// File: rtl/blob_raster.sv
// Rasterises N particles as discs into a DIM x DIM bitmap, one pixel per cycle.
// Latency: DIM*DIM+2 cycles from frame-timer tick to new matrix and frame_done.
// Backpressure: none; ticks arriving while busy are dropped and flagged on overrun.
module blob_raster
    import blob_raster_pkg::*;
#(
    parameter int N            = 4,
    parameter int DIM          = 16,
    parameter int FRAC_BITS    = 4,
    parameter int RADIUS_SQ    = 2,
    parameter int FRAME_CYCLES = 10000,
    parameter int TRAIL_FRAMES = 8
) (
    input  logic          clk,
    input  logic          reset,
    blob_raster_if.slave  bus
);
    localparam int NPIX = DIM * DIM;
    localparam int LD   = $clog2(DIM);
    localparam int PW   = $clog2(NPIX);
    localparam int TW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int TCW  = (TRAIL_FRAMES > 1) ? $clog2(TRAIL_FRAMES) : 1;

    logic [TW-1:0]          timer;
    logic                   tick;
    state_t                 state;
    logic [PW-1:0]          pix;
    logic [NPIX-1:0]        back;
    logic [NPIX-1:0]        matrix_q;
    logic [N*COORD_W-1:0]   snap_x;
    logic [N*COORD_W-1:0]   snap_y;
    logic                   snap_trail;
    logic [TCW-1:0]         trail_cnt;
    logic                   clear_due;
    logic                   frame_done_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic [N-1:0]           hits;
    logic signed [COORD_W-1:0] px_c;
    logic signed [COORD_W-1:0] py_c;

    assign tick = (timer == TW'(FRAME_CYCLES - 1));

    // Pixel index splits into column (low bits) and row (high bits).
    assign px_c = {{(COORD_W-LD){1'b0}}, pix[LD-1:0]};
    assign py_c = {{(COORD_W-(PW-LD)){1'b0}}, pix[PW-1:LD]};

    // One comparator per particle, all evaluated against the current pixel.
    for (genvar i = 0; i < N; i++) begin : g_hit
        disc_hit #(
            .FRAC_BITS (FRAC_BITS),
            .RADIUS_SQ (RADIUS_SQ)
        ) u_hit (
            .px    (px_c),
            .py    (py_c),
            .pos_x (snap_x[i*COORD_W +: COORD_W]),
            .pos_y (snap_y[i*COORD_W +: COORD_W]),
            .hit   (hits[i])
        );
    end

    // Plain frames always replace; trail frames replace only when history is due to clear.
    assign clear_due = !snap_trail || (trail_cnt == TCW'(TRAIL_FRAMES - 1));

    // Free-running frame timer, independent of freeze and FSM state.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Frame FSM: snapshot on tick, scan every pixel, then commit to the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pix          <= '0;
            back         <= '0;
            matrix_q     <= '0;
            snap_x       <= '0;
            snap_y       <= '0;
            snap_trail   <= 1'b0;
            trail_cnt    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && !bus.freeze) begin
                        snap_x     <= bus.pos_x;
                        snap_y     <= bus.pos_y;
                        snap_trail <= bus.trail_mode;
                        pix        <= '0;
                        busy_q     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    overrun_q <= tick;
                    back[pix] <= |hits;
                    if (pix == PW'(NPIX - 1)) begin
                        pix   <= '0;
                        state <= COMMIT;
                    end else begin
                        pix <= pix + PW'(1);
                    end
                end
                COMMIT: begin
                    overrun_q <= tick;
                    if (clear_due) begin
                        matrix_q  <= back;
                        trail_cnt <= '0;
                    end else begin
                        matrix_q  <= matrix_q | back;
                        trail_cnt <= trail_cnt + TCW'(1);
                    end
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.matrix     = matrix_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
endmodule
